hex_scan_ctrl: RTL and testbench

Time-multiplexed scan scheduler for the 8-digit seven-segment display behind the hex system-bus peripheral. Takes the 8 digit nibbles and enable bitmask from the register block and sequences one digit at a time onto the shared segment bus. Each digit slot has a guard blanking interval to prevent ghosting. Registered, active-low outputs drive the board pins directly.

---
 rtl/hex_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Scan scheduler for an 8-digit seven-segment display: one digit per slot, guard blanking, active-low pins.
// Optional brightness PWM inside the ON window when HEX_SCAN_PWM_EN is defined.
module hex_scan_ctrl #(
    parameter int BLANK_CYCLES = 16,
    parameter int ON_CYCLES    = 2496
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] digits_i,
    input  logic [7:0]  bitmask_i,
    input  logic [3:0]  bright_i,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o,
    output logic [2:0]  digit_idx_o,
    output logic        frame_o
);
    localparam int MAX_CYCLES = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [6:0]    DARK_LED   = 7'h7F;
    localparam logic [7:0]    DARK_SEL   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    idx_nx;
    logic [3:0]    slot_nib;
    logic          slot_mask;
    logic          pwm_off;
    logic [3:0]    nib_nx;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign cnt_nx = cnt + CW'(1);
    assign idx_nx = digit_idx_o + 3'd1;
    assign nib_nx = digits_i[{idx_nx, 2'b00} +: 4];

`ifdef HEX_SCAN_PWM_EN
    localparam int PW = CW + 5;

    logic [PW-1:0] bright_ext;
    logic [PW-1:0] thr_prod;
    logic [CW:0]   thr;

    // (bright+1)*ON_CYCLES never exceeds 16*ON_CYCLES, so PW bits hold it untruncated.
    assign bright_ext = {{(PW-4){1'b0}}, bright_i} + PW'(1);
    assign thr_prod   = bright_ext * PW'(ON_CYCLES);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            thr <= '0;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            thr <= thr_prod[PW-1:4];
        end
    end

    assign pwm_off = ({1'b0, cnt_nx} >= thr);
`else
    logic bright_unused;
    assign bright_unused = ^bright_i;
    assign pwm_off       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            slot_nib    <= '0;
            slot_mask   <= 1'b0;
            hex_led_o   <= DARK_LED;
            hex_sel_o   <= DARK_SEL;
            digit_idx_o <= '0;
            frame_o     <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (!en_i) begin
                state       <= IDLE;
                cnt         <= '0;
                digit_idx_o <= '0;
                hex_led_o   <= DARK_LED;
                hex_sel_o   <= DARK_SEL;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        cnt         <= '0;
                        digit_idx_o <= '0;
                        slot_nib    <= digits_i[3:0];
                        slot_mask   <= bitmask_i[0];
                        hex_led_o   <= DARK_LED;
                        hex_sel_o   <= DARK_SEL;
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= ON;
                            cnt   <= '0;
                            if (slot_mask) begin
                                hex_led_o <= seg_decode(slot_nib);
                                hex_sel_o <= ~(8'b1 << digit_idx_o);
                            end
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                    ON: begin
                        if (cnt == ON_LAST) begin
                            state       <= BLANK;
                            cnt         <= '0;
                            digit_idx_o <= idx_nx;
                            slot_nib    <= nib_nx;
                            slot_mask   <= bitmask_i[idx_nx];
                            hex_led_o   <= DARK_LED;
                            hex_sel_o   <= DARK_SEL;
                            frame_o     <= (digit_idx_o == 3'd7);
                        end else begin
                            cnt <= cnt_nx;
                            // Past the PWM threshold the digit stays dark for the rest of the window.
                            if (pwm_off) begin
                                hex_led_o <= DARK_LED;
                                hex_sel_o <= DARK_SEL;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        hex_led_o <= DARK_LED;
                        hex_sel_o <= DARK_SEL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: timeline-based reference model compared every cycle,
// plus directed literal checks of scan order, masking, tearing, enable drop, reset and PWM.
module tb_hex_scan_ctrl;
    localparam int BLANK = 2;
    localparam int ON    = 16;
    localparam int SLOT  = BLANK + ON;
`ifdef HEX_SCAN_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] digits_i = '0;
    logic [7:0]  bitmask_i = '0;
    logic [3:0]  bright_i = '0;
    logic [6:0]  hex_led_o;
    logic [7:0]  hex_sel_o;
    logic [2:0]  digit_idx_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_scan_ctrl #(.BLANK_CYCLES(BLANK), .ON_CYCLES(ON)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .digits_i    (digits_i),
        .bitmask_i   (bitmask_i),
        .bright_i    (bright_i),
        .hex_led_o   (hex_led_o),
        .hex_sel_o   (hex_sel_o),
        .digit_idx_o (digit_idx_o),
        .frame_o     (frame_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Model: t = cycles since the scan started; slot and phase position follow by division.
    bit         run = 1'b0;
    int         t = 0;
    logic [3:0] m_nib = '0;
    bit         m_mask = 1'b0;
    int         m_thr = 0;
    logic [6:0] e_led = 7'h7F;
    logic [7:0] e_sel = 8'hFF;
    logic [2:0] e_idx = '0;
    logic       e_frame = 1'b0;

    always @(posedge clk_i) begin
        int slot, pos;
        bit lit;
        if (!rst_i || !en_i) begin
            run = 1'b0;
            e_led = 7'h7F; e_sel = 8'hFF; e_idx = '0; e_frame = 1'b0;
            if (!rst_i) begin m_nib = '0; m_mask = 1'b0; end
        end else begin
            if (!run) begin run = 1'b1; t = 0; end
            else t = t + 1;
            slot = (t / SLOT) % 8;
            pos  = t % SLOT;
            if (pos == 0) begin
                m_nib  = digits_i[4*slot +: 4];
                m_mask = bitmask_i[slot];
            end
            if (pos == BLANK) m_thr = PWM ? (((int'(bright_i) + 1) * ON) >> 4) : ON;
            lit = (pos >= BLANK) && m_mask && ((pos - BLANK) < m_thr);
            e_idx   = 3'(slot);
            e_frame = (pos == 0) && (t > 0) && (slot == 0);
            e_sel   = lit ? ~(8'd1 << slot) : 8'hFF;
            e_led   = lit ? seg_tab[m_nib] : 7'h7F;
        end
    end

    always @(negedge clk_i) begin
        logic [18:0] exp_v, got_v;
        exp_v = rst_i ? {e_led, e_sel, e_idx, e_frame} : {7'h7F, 8'hFF, 3'd0, 1'b0};
        got_v = {hex_led_o, hex_sel_o, digit_idx_o, frame_o};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL model cyc=%0d got led=%h sel=%h idx=%0d frame=%b want led=%h sel=%h idx=%0d frame=%b",
                     cyc, hex_led_o, hex_sel_o, digit_idx_o, frame_o,
                     exp_v[18:12], exp_v[11:4], exp_v[3:1], exp_v[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic expect_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_lit(input int d);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1);
            if (digit_idx_o == 3'(d) && hex_sel_o != 8'hFF) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_lit digit %0d timed out", d);
        end
    endtask

    task automatic wait_idx_not(input int d);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1);
            if (digit_idx_o != 3'(d)) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_idx_not %0d timed out", d);
        end
    endtask

    task automatic wait_frame(output int at);
        bit found;
        found = 1'b0;
        at = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1);
            if (frame_o) begin found = 1'b1; at = cyc; end
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_frame timed out");
        end
    endtask

    task automatic count_lit(input int n, output int lit);
        lit = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (hex_sel_o != 8'hFF) lit++;
        end
    endtask

    initial begin
        int a, b, lit;
        logic [7:0] seen;

        tick(3);
        expect_eq("reset_sel", hex_sel_o, 8'hFF);
        expect_eq("reset_led", hex_led_o, 7'h7F);
        rst_i = 1'b1;
        tick(3);
        expect_eq("idle_dark_sel", hex_sel_o, 8'hFF);

        digits_i = 32'h76543210; bitmask_i = 8'hFF; en_i = 1'b1;
        tick(2);
        expect_eq("blank_dark_sel", hex_sel_o, 8'hFF);
        tick(1);
        expect_eq("first_lit_led", hex_led_o, 7'h40);
        expect_eq("first_lit_sel", hex_sel_o, 8'hFE);
        expect_eq("first_lit_idx", digit_idx_o, 0);

        wait_lit(7);
        expect_eq("digit7_sel", hex_sel_o, 8'h7F);
        expect_eq("digit7_led", hex_led_o, 7'h78);
        wait_frame(a);
        wait_frame(b);
        expect_eq("frame_period", b - a, 144);

        bitmask_i = 8'h05;
        wait_frame(a);
        seen = '0;
        for (int i = 0; i < 144; i++) begin
            tick(1);
            seen = seen | ~hex_sel_o;
        end
        expect_eq("mask05_lit_set", seen, 8'h05);
        expect_eq("mask05_period", frame_o, 1);

        bitmask_i = 8'hFF;
        wait_lit(3);
        digits_i = 32'h7654F210;
        tick(4);
        expect_eq("tear_idx", digit_idx_o, 3);
        expect_eq("tear_led_held", hex_led_o, 7'h30);
        wait_idx_not(3);
        wait_lit(3);
        expect_eq("tear_led_next", hex_led_o, 7'h0E);

        wait_lit(5);
        en_i = 1'b0;
        tick(1);
        expect_eq("drop_sel", hex_sel_o, 8'hFF);
        expect_eq("drop_idx", digit_idx_o, 0);
        expect_eq("drop_frame", frame_o, 0);
        tick(3);
        en_i = 1'b1;
        tick(3);
        expect_eq("reen_sel", hex_sel_o, 8'hFE);
        expect_eq("reen_led", hex_led_o, 7'h40);

        bright_i = 4'd3;
        wait_frame(a);
        count_lit(SLOT, lit);
        expect_eq("pwm_b3_lit", lit, PWM ? 4 : 16);
        bright_i = 4'd15;
        wait_frame(a);
        count_lit(SLOT, lit);
        expect_eq("pwm_b15_lit", lit, 16);

        wait_lit(1);
        rst_i = 1'b0;
        #1;
        expect_eq("rst_mid_sel", hex_sel_o, 8'hFF);
        expect_eq("rst_mid_led", hex_led_o, 7'h7F);
        expect_eq("rst_mid_idx", digit_idx_o, 0);
        expect_eq("rst_mid_frame", frame_o, 0);
        en_i = 1'b0;
        tick(2);
        rst_i = 1'b1;
        tick(3);
        expect_eq("rst_release_dark", hex_sel_o, 8'hFF);

        en_i = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if ($urandom_range(0, 7) == 0)   digits_i  = $urandom;
            if ($urandom_range(0, 15) == 0)  bitmask_i = 8'($urandom);
            if ($urandom_range(0, 15) == 0)  bright_i  = 4'($urandom);
            if ($urandom_range(0, 299) == 0) en_i      = ~en_i;
            else if (!en_i && $urandom_range(0, 9) == 0) en_i = 1'b1;
            if ($urandom_range(0, 799) == 0) rst_i = 1'b0;
            else rst_i = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
